divisor8bit: RTL and testbench

Sequential unsigned integer divider for the single-cycle MIPS datapath's multi-cycle extension (DIVU support). It accepts a dividend/divisor pair on a start pulse and runs one restoring-division iteration per clock. Each iteration is a trial subtraction, which is the inverse of the ripple adder chain already in the codebase. It returns quotient and remainder with a one-cycle done pulse, holding results stable for the HI/LO write-back logic.

---
 rtl/divisor8bit_pkg.sv | 18 +
 rtl/divisor8bit_subtrator.sv | 40 ++++
 rtl/divisor8bit.sv | 117 +++++++++++
 tb/tb_divisor8bit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/divisor8bit_pkg.sv
// Shared constants for the DIVU divider: default datapath width and FSM state encodings.
package divisor8bit_pkg;

    // Default operand width, also used by the ALU and the HI/LO register file.
    localparam int WIDTH_DEF = 8;

    // Divider control state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        FIN  = ST_FIN
    } div_state_e;

endpackage

// File: rtl/divisor8bit_subtrator.sv
// Ripple subtractor: a - b computed as a + ~b + 1 through a chain of full-adder cells.
// borrow_n_o is the final carry-out; 1 means a >= b (no borrow).

// Single-bit full adder cell.
module somador1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);
    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module subtrator #(
    parameter int W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_n_o
);
    logic [W:0] c;

    assign c[0] = 1'b1;

    // One adder cell per bit with the subtrahend inverted.
    for (genvar i = 0; i < W; i++) begin : g_bit
        somador1bit u_fa (
            .a_i   (a_i[i]),
            .b_i   (~b_i[i]),
            .cin_i (c[i]),
            .s_o   (diff_o[i]),
            .cout_o(c[i+1])
        );
    end

    assign borrow_n_o = c[W];
endmodule

// File: rtl/divisor8bit.sv
// Sequential unsigned restoring divider: one trial subtraction per clock,
// quotient/remainder/div_zero registered and held after a one-cycle done pulse.
module divisor8bit
    import divisor8bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_e       state_q;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvsr_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, dz_q;
    logic [WIDTH-1:0] quot_q, remd_q;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             no_borrow;

    // The partial remainder never reaches bit WIDTH after a restoring step,
    // so its top bit only exists to hold the subtractor's full width.
    logic             unused_rem;
    assign unused_rem = rem_q[WIDTH];

    assign trial = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};

    subtrator #(.W(WIDTH + 1)) u_sub (
        .a_i       (trial),
        .b_i       ({1'b0, dvsr_q}),
        .diff_o    (diff),
        .borrow_n_o(no_borrow)
    );

    // Restoring step: keep the difference only when it did not underflow.
    always_comb begin
        rem_d = no_borrow ? diff : trial;
        q_d   = {q_q[WIDTH-2:0], no_borrow};
    end

    // Control FSM, iteration counter, shift registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dvsr_q <= divisor;
                        q_q    <= dividend;
                        rem_q  <= '0;
                        cnt_q  <= '0;
                        dz_q   <= 1'b0;
                        if (divisor == '0) begin
                            // Divide-by-zero short-circuits straight to FIN.
                            quot_q  <= '1;
                            remd_q  <= dividend;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        quot_q  <= q_d;
                        remd_q  <= rem_d[WIDTH-1:0];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: state_q <= IDLE;
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = remd_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_divisor8bit.sv
// Bench for divisor8bit: directed cases plus a random sweep, checked by a
// scoreboard whose expectations come from plain integer / and %.
module tb_divisor8bit;
    localparam int W = 8;

    logic         clk, rst, start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_zero;
    logic [W-1:0] quotient, remainder;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    divisor8bit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_zero", div_zero, e.dz);
                chk("done_latency", cyc, e.cyc);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    // Drive a one-cycle start and record what the block must return.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.q   = (b != 0) ? a / b : 8'hFF;
        e.r   = (b != 0) ? a % b : a;
        e.dz  = (b == 0);
        e.cyc = cyc + ((b != 0) ? W + 1 : 1);
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        #2;
    endtask

    // Wait for the scoreboard to drain; optionally scramble inputs meanwhile.
    task automatic wait_done(input bit scramble);
        int guard = 0;
        while (sb.size() != 0 && guard < 40) begin
            if (scramble) begin
                dividend = W'($urandom);
                divisor  = W'($urandom);
                start    = $urandom_range(0, 1);
            end
            @(negedge clk);
            #2;
            guard++;
        end
        start = 1'b0;
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    function automatic logic [W-1:0] pick();
        int s = $urandom_range(0, 7);
        if (s == 0) return '0;
        if (s == 1) return '1;
        return W'($urandom);
    endfunction

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_zero", div_zero, 0);
        rst = 1'b0;

        // 200 / 7 with busy profile over cycles 1..9.
        issue(8'd200, 8'd7);
        for (int k = 1; k <= W + 1; k++) begin
            chk("busy_profile", busy, (k <= W) ? 1 : 0);
            @(negedge clk);
            #2;
        end
        wait_done(0);

        issue(8'd255, 8'd1);   wait_done(0);
        issue(8'd3, 8'd10);    wait_done(0);
        issue(8'd255, 8'd255); wait_done(0);

        // Divide by zero: done in cycle 1, busy never rises.
        issue(8'd5, 8'd0);
        chk("dz_busy", busy, 0);
        wait_done(0);

        // Second start during a run is ignored; results then hold.
        issue(8'd100, 8'd9);
        repeat (2) @(negedge clk);
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_quotient", quotient, 11);
            chk("hold_remainder", remainder, 1);
            chk("hold_done", done, 0);
        end

        // Reset mid-run: outputs clear asynchronously, no done follows.
        issue(8'd200, 8'd7);
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        chk("midrst_div_zero", div_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        issue(8'd17, 8'd4);
        wait_done(0);

        // Random sweep with operand scrambling and stray starts while busy.
        for (int n = 0; n < 1500; n++) begin
            issue(pick(), pick());
            wait_done(1);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
